// File: rtl/power_alu_arbiter.sv
// Two-master arbiter/sequencer feeding one shared combinational PowerALU.
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins ties); default is round-robin.
module power_alu_arbiter #(
  parameter int W  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [SW-1:0] req0_s,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [SW-1:0] req1_s,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [W-1:0]  rsp0_data,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [W-1:0]  rsp1_data,
  output logic [SW-1:0] alu_s,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W-1:0]  alu_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state;
  logic         gnt;
  logic         last;
  logic         win;
  logic         accept;
  logic [W-1:0] result;

  // win is the requester id that gets ready when both are valid or only requester 1 is
  always_comb begin
`ifdef ALU_ARB_FIXED_PRI_EN
    win = !req0_valid;
`else
    win = (req0_valid && req1_valid) ? !last : !req0_valid;
`endif
  end

  assign req0_ready = !rst && (state == IDLE) && req0_valid && !win;
  assign req1_ready = !rst && (state == IDLE) && req1_valid && win;
  assign accept     = req0_ready || req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      alu_s  <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      result <= '0;
      gnt    <= 1'b0;
      last   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_s <= win ? req1_s : req0_s;
            alu_a <= win ? req1_a : req0_a;
            alu_b <= win ? req1_b : req0_b;
            gnt   <= win;
`ifndef ALU_ARB_FIXED_PRI_EN
            last  <= win;
`endif
            state <= EXEC;
          end
        end
        EXEC: begin
          result <= alu_out;
          state  <= RESP;
        end
        RESP: begin
          if (gnt ? rsp1_ready : rsp0_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the granted port sees the result; the other response port reads zero
  assign rsp0_valid = (state == RESP) && !gnt;
  assign rsp1_valid = (state == RESP) && gnt;
  assign rsp0_data  = rsp0_valid ? result : '0;
  assign rsp1_data  = rsp1_valid ? result : '0;

endmodule

// File: tb/tb_power_alu_arbiter.sv
// Scoreboard bench for power_alu_arbiter with an adder standing in for PowerALU.
// A transaction-level model predicts grants and results; a monitor checks completed responses.
module tb_power_alu_arbiter;
  localparam int W  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [SW-1:0] req0_s, req1_s;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0]  rsp0_data, rsp1_data;
  logic [SW-1:0] alu_s;
  logic [W-1:0]  alu_a, alu_b, alu_out;

  power_alu_arbiter #(.W(W), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_s(req0_s), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_s(req1_s), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  assign alu_out = alu_a + alu_b;
  always #5 clk = ~clk;

  typedef struct {
    int           port;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Requests the masters are currently offering (held until granted)
  logic          pend[2];
  logic [SW-1:0] ps[2];
  logic [W-1:0]  pa[2];
  logic [W-1:0]  pb[2];
  logic          rr[2];

  // Transaction-level model: one op in flight, age counts edges since accept
  bit            mBusy;
  int            mAge;
  int            mGnt;
  int            mLast;
  logic [SW-1:0] mS;
  logic [W-1:0]  mA, mB;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mAge = 0; mGnt = 0; mLast = 1;
    mS = '0; mA = '0; mB = '0;
  endtask

  function automatic int pick();
    if (pend[0] && pend[1]) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      return 0;
`else
      return 1 - mLast;
`endif
    end
    if (pend[0]) return 0;
    if (pend[1]) return 1;
    return -1;
  endfunction

  task automatic setReq(int k, logic [SW-1:0] s, logic [W-1:0] a, logic [W-1:0] b);
    pend[k] = 1'b1; ps[k] = s; pa[k] = a; pb[k] = b;
  endtask

  task automatic checkOutput();
    int w;
    logic ev0, ev1;
    logic [W-1:0] ed;
    w   = mBusy ? -1 : pick();
    ev0 = mBusy && (mAge >= 1) && (mGnt == 0);
    ev1 = mBusy && (mAge >= 1) && (mGnt == 1);
    ed  = (sb.size() > 0) ? sb[0].data : '0;
    chk("req0_ready", req0_ready, (w == 0));
    chk("req1_ready", req1_ready, (w == 1));
    chk("alu_s", alu_s, mS);
    chk("alu_a", alu_a, mA);
    chk("alu_b", alu_b, mB);
    chk("rsp0_valid", rsp0_valid, ev0);
    chk("rsp1_valid", rsp1_valid, ev1);
    chk("rsp0_data", rsp0_data, ev0 ? ed : '0);
    chk("rsp1_data", rsp1_data, ev1 ? ed : '0);
  endtask

  task automatic applyStimulus();
    int w;
    logic [W-1:0] sum;
    req0_valid = pend[0]; req0_s = ps[0]; req0_a = pa[0]; req0_b = pb[0];
    req1_valid = pend[1]; req1_s = ps[1]; req1_a = pa[1]; req1_b = pb[1];
    rsp0_ready = rr[0];   rsp1_ready = rr[1];
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    if (!mBusy) begin
      w = pick();
      if (w >= 0) begin
        mBusy = 1; mAge = 0; mGnt = w;
`ifndef ALU_ARB_FIXED_PRI_EN
        mLast = w;
`endif
        mS = ps[w]; mA = pa[w]; mB = pb[w];
        sum = pa[w] + pb[w];
        sb.push_back('{w, sum});
        pend[w] = 1'b0;
      end
    end else if (mAge >= 1 && rr[mGnt]) begin
      mBusy = 0;
    end else begin
      mAge++;
    end
  endtask

  task automatic popCheck(int p, logic [W-1:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("[TB] FAIL unexpected_rsp: port %0d data %0h, expected no response", p, d);
    end else begin
      e = sb.pop_front();
      chk("rsp_port", p, e.port);
      chk("rsp_data", d, e.data);
    end
  endtask

  // Monitor: every completed response handshake consumes one scoreboard entry
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (rsp0_valid && rsp0_ready) popCheck(0, rsp0_data);
        if (rsp1_valid && rsp1_ready) popCheck(1, rsp1_data);
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; ps[k] = '0; pa[k] = '0; pb[k] = '0; rr[k] = 1'b1;
    end
    modelReset();
    req0_valid = 0; req1_valid = 0; req0_s = '0; req1_s = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1; rsp1_ready = 1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset rsp0_valid", rsp0_valid, 0);
    chk("reset rsp1_valid", rsp1_valid, 0);
    chk("reset alu_a", alu_a, 0);
    chk("reset alu_b", alu_b, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single request on port 0
    setReq(0, 4'b0000, 8'd101, 8'd62);
    applyStimulus();
    applyStimulus();
    chk("single rsp0_valid", rsp0_valid, 1);
    chk("single rsp0_data", rsp0_data, 8'd163);
    chk("single alu_s", alu_s, 4'b0000);
    applyStimulus();
    applyStimulus();
    chk("single rsp0_valid low", rsp0_valid, 0);

    // Continuous tie
    for (int i = 0; i < 9; i++) begin
      if (!pend[0]) setReq(0, 4'd0, 8'd1, 8'd2);
      if (!pend[1]) setReq(1, 4'd0, 8'd10, 8'd20);
      applyStimulus();
    end
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 4; i++) applyStimulus();

    // Response backpressure on port 1 while port 0 waits
    rr[1] = 1'b0;
    setReq(1, 4'd3, 8'd255, 8'd254);
    applyStimulus();
    setReq(0, 4'd5, 8'd3, 8'd4);
    for (int i = 0; i < 6; i++) applyStimulus();
    chk("bp rsp1_valid", rsp1_valid, 1);
    chk("bp rsp1_data", rsp1_data, 8'd253);
    rr[1] = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus();

    // Wrap-around
    setReq(0, 4'd1, 8'd255, 8'd1);
    applyStimulus();
    applyStimulus();
    chk("wrap rsp0_valid", rsp0_valid, 1);
    chk("wrap rsp0_data", rsp0_data, 8'd0);
    applyStimulus();

    // Idle hold
    for (int i = 0; i < 10; i++) applyStimulus();

    // Reset during EXEC
    setReq(0, 4'd2, 8'd5, 8'd6);
    setReq(1, 4'd4, 8'd7, 8'd8);
    applyStimulus();
    #2;
    rst = 1'b1;
    #1;
    chk("rst rsp0_valid", rsp0_valid, 0);
    chk("rst rsp1_valid", rsp1_valid, 0);
    chk("rst alu_s", alu_s, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    pend[0] = 0; pend[1] = 0;
    req0_valid = 0; req1_valid = 0;
    modelReset();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    setReq(0, 4'd0, 8'd1, 8'd2);
    setReq(1, 4'd0, 8'd10, 8'd20);
    for (int i = 0; i < 4; i++) applyStimulus();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && ($urandom_range(1, 0) == 1))
          setReq(k, SW'($urandom), W'($urandom), W'($urandom));
        rr[k] = ($urandom_range(9, 0) < 7);
      end
      applyStimulus();
    end

    // Drain
    pend[0] = 0; pend[1] = 0; rr[0] = 1; rr[1] = 1;
    for (int i = 0; i < 6; i++) applyStimulus();
    chk("scoreboard empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
